// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the EX-stage multiply/divide unit.
package pipeline_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the shift-add multiplier or restoring divider on the
// 2*XLEN work register.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] p_in,
  input  logic [XLEN-1:0]   b_in,
  input  logic              is_div,
  output logic [2*XLEN-1:0] p_out
);

  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] p_shl;
  logic [XLEN:0]     rem_wide;
  logic [XLEN-1:0]   rem_diff;

  always_comb begin
    add_sum  = {1'b0, p_in[2*XLEN-1:XLEN]} + (p_in[0] ? {1'b0, b_in} : '0);
    p_shl    = {p_in[2*XLEN-2:0], 1'b0};
    // The bit shifted out of the top must take part in the compare.
    rem_wide = {p_in[2*XLEN-1], p_shl[2*XLEN-1:XLEN]};
    rem_diff = rem_wide[XLEN-1:0] - b_in;

    if (is_div) begin
      p_out = p_shl;
      if (rem_wide >= {1'b0, b_in}) begin
        p_out[2*XLEN-1:XLEN] = rem_diff;
        p_out[0]             = 1'b1;
      end
    end else begin
      p_out = {add_sum, p_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit in EX; stalls IF/ID and
// ID/EX while iterating one bit per cycle.
//
// state | meaning
// IDLE  | waiting for a muldiv instruction in ID/EX
// BUSY  | iterating, one bit per cycle for XLEN cycles
// DONE  | result presented to EX/MEM for one cycle
module ex_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] rs1Data_in,
  input  logic [XLEN-1:0] rs2Data_in,
  input  logic [4:0]      rd_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out
);
  import pipeline_pkg::*;

  localparam int PW = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d, p_step;
  muldiv_op_t       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  res_q, res_d, res_calc;
  logic             div0_q, div0_d;
  logic             accept;
  logic             in_div0;
  logic             op_is_div;

  assign accept    = (state_q == IDLE) && start_in && !flush_in;
  assign in_div0   = op_in[1] && (rs2Data_in == '0);
  assign op_is_div = (op_q == DIVU) || (op_q == REMU);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .p_in   (p_q),
    .b_in   (b_q),
    .is_div (op_is_div),
    .p_out  (p_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_in) state_d = in_div0 ? DONE : BUSY;
        BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_out    = !rst && (accept || ((state_q == BUSY) && !flush_in));
    done_out     = !rst && (state_q == DONE) && !flush_in;
    RegWrite_out = done_out;
    result_out   = done_out ? res_calc : res_q;
    rd_out       = rd_q;
  end

  // Divide by zero skips BUSY, so P still holds {0, A} in DONE.
  always_comb begin
    case (op_q)
      MUL:     res_calc = p_q[XLEN-1:0];
      MULHU:   res_calc = p_q[PW-1:XLEN];
      DIVU:    res_calc = div0_q ? '1 : p_q[XLEN-1:0];
      REMU:    res_calc = div0_q ? p_q[XLEN-1:0] : p_q[PW-1:XLEN];
      default: res_calc = p_q[XLEN-1:0];
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    op_d   = op_q;
    rd_d   = rd_q;
    b_d    = b_q;
    div0_d = div0_q;
    res_d  = res_q;
    if (accept) begin
      op_d   = muldiv_op_t'(op_in);
      rd_d   = rd_in;
      b_d    = rs2Data_in;
      p_d    = {{XLEN{1'b0}}, rs1Data_in};
      cnt_d  = '0;
      div0_d = in_div0;
    end else if ((state_q == BUSY) && !flush_in) begin
      p_d   = p_step;
      cnt_d = cnt_q + 1'b1;
    end
    if (done_out) res_d = res_calc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      p_q    <= '0;
      op_q   <= MUL;
      rd_q   <= '0;
      b_q    <= '0;
      div0_q <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      op_q   <= op_d;
      rd_q   <= rd_d;
      b_q    <= b_d;
      div0_q <= div0_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, div-by-zero, flush, reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [1:0]  op_in;
  logic [63:0] rs1Data_in;
  logic [63:0] rs2Data_in;
  logic [4:0]  rd_in;
  logic        flush_in;
  logic        stall_out;
  logic        done_out;
  logic [63:0] result_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;

  int n_pass  = 0;
  int n_total = 0;

  ex_muldiv_unit #(.XLEN(64), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .op_in        (op_in),
    .rs1Data_in   (rs1Data_in),
    .rs2Data_in   (rs2Data_in),
    .rd_in        (rd_in),
    .flush_in     (flush_in),
    .stall_out    (stall_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .rd_out       (rd_out),
    .RegWrite_out (RegWrite_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd,
                        output logic [63:0] res, output int lat, output int stalls,
                        output logic [4:0] rd_o, output logic rw,
                        output logic done_after, output logic [63:0] res_after);
    logic seen;
    seen = 1'b0; lat = 0; stalls = 0; res = '0; rd_o = '0; rw = 1'b0;
    op_in = op; rs1Data_in = a; rs2Data_in = b; rd_in = rd; start_in = 1'b1;
    for (int n = 1; n <= 150 && !seen; n++) begin
      #3;
      if (stall_out) stalls++;
      if (done_out) begin
        seen = 1'b1; lat = n; res = result_out; rd_o = rd_out; rw = RegWrite_out;
      end
      @(posedge clk); #1;
      if (n == 1) begin
        start_in   = 1'b0;
        op_in      = ~op;
        rs1Data_in = 64'hDEAD_BEEF_0123_4567;
        rs2Data_in = 64'h3;
        rd_in      = ~rd;
      end
    end
    #3;
    done_after = done_out;
    res_after  = result_out;
    @(posedge clk); #1;
  endtask

  logic [63:0] res, res_after;
  int          lat, stalls, n_done;
  logic [4:0]  rd_o;
  logic        rw, done_after;

  initial begin
    rst = 1'b1; start_in = 1'b0; op_in = 2'b00; rs1Data_in = '0; rs2Data_in = '0;
    rd_in = '0; flush_in = 1'b0;
    #2;
    chk("rst_stall",  64'(stall_out),    64'd0);
    chk("rst_done",   64'(done_out),     64'd0);
    chk("rst_result", result_out,        64'd0);
    chk("rst_rd",     64'(rd_out),       64'd0);
    chk("rst_rw",     64'(RegWrite_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(2'b00, 64'd7, 64'd6, 5'd5, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("mul_res",        res,           64'd42);
    chk("mul_lat",        64'(lat),      64'd66);
    chk("mul_stalls",     64'(stalls),   64'd65);
    chk("mul_rd",         64'(rd_o),     64'd5);
    chk("mul_rw",         64'(rw),       64'd1);
    chk("mul_done_pulse", 64'(done_after), 64'd0);
    chk("mul_res_hold",   res_after,     64'd42);

    run_op(2'b01, '1, '1, 5'd9, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("mulhu_ones", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'b00, '1, '1, 5'd9, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("mul_ones", res, 64'h1);
    run_op(2'b01, 64'h8000_0000_0000_0000, 64'd4, 5'd1, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("mulhu_2p65", res, 64'd2);

    run_op(2'b10, 64'd100, 64'd7, 5'd3, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("divu_res", res, 64'd14);
    chk("divu_lat", 64'(lat), 64'd66);
    run_op(2'b11, 64'd100, 64'd7, 5'd3, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("remu_res", res, 64'd2);
    chk("remu_lat", 64'(lat), 64'd66);

    run_op(2'b10, 64'd123, 64'd0, 5'd4, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("divu0_res",    res,         64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu0_lat",    64'(lat),    64'd2);
    chk("divu0_stalls", 64'(stalls), 64'd1);
    run_op(2'b11, 64'd123, 64'd0, 5'd4, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("remu0_res", res,      64'd123);
    chk("remu0_lat", 64'(lat), 64'd2);

    // Flush at BUSY cycle 30.
    op_in = 2'b00; rs1Data_in = 64'd11; rs2Data_in = 64'd13; rd_in = 5'd7; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    repeat (29) @(posedge clk);
    #1 flush_in = 1'b1;
    #2;
    chk("flush_stall_comb", 64'(stall_out), 64'd0);
    chk("flush_done_comb",  64'(done_out),  64'd0);
    @(posedge clk); #1 flush_in = 1'b0;
    #2;
    chk("flush_stall_next", 64'(stall_out), 64'd0);
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #3;
      if (done_out) n_done++;
    end
    chk("flush_no_done", 64'(n_done), 64'd0);
    chk("flush_res_kept", result_out, 64'd123);
    @(posedge clk); #1;
    run_op(2'b00, 64'd12345, 64'd1000, 5'd8, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("post_flush_res", res,      64'd12345000);
    chk("post_flush_lat", 64'(lat), 64'd66);

    // Reset at BUSY cycle 10.
    op_in = 2'b10; rs1Data_in = 64'd1000; rs2Data_in = 64'd3; rd_in = 5'd12; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_stall",  64'(stall_out),    64'd0);
    chk("midrst_done",   64'(done_out),     64'd0);
    chk("midrst_result", result_out,        64'd0);
    chk("midrst_rd",     64'(rd_out),       64'd0);
    chk("midrst_rw",     64'(RegWrite_out), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    #2;
    chk("postrst_stall", 64'(stall_out), 64'd0);
    @(posedge clk); #1;

    run_op(2'b10, '1, 64'h8000_0000_0000_0001, 5'd2, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("divu_big_q", res, 64'd1);
    run_op(2'b11, '1, 64'h8000_0000_0000_0001, 5'd2, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("remu_big_r", res, 64'h7FFF_FFFF_FFFF_FFFE);
    run_op(2'b10, '1, 64'h10, 5'd31, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("divu_16_q",  res,        64'h0FFF_FFFF_FFFF_FFFF);
    chk("divu_16_rd", 64'(rd_o),  64'd31);
    run_op(2'b11, '1, 64'h10, 5'd31, res, lat, stalls, rd_o, rw, done_after, res_after);
    chk("remu_16_r", res, 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
